// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter for two requester groups sharing one 3-bit channel.
// Bounded tenure under contention, registered Moore grant/select outputs,
// and a registered data/valid stage for the granted group.
module mux_share_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reqA,
    input  logic       reqB,
    input  logic [2:0] dataA,
    input  logic [2:0] dataB,
    output logic       gntA,
    output logic       gntB,
    output logic       sel,
    output logic       out_valid,
    output logic [2:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [2:0] HOLD_MAX = 3'(MAX_HOLD);

    state_t     state;
    state_t     state_nxt;
    logic       last;       // 0 = A granted most recently, 1 = B
    logic [2:0] hold;
    logic [2:0] hold_nxt;
    logic       valid_nxt;
    logic [2:0] data_nxt;

    // Next-state and tenure-counter decision for the current grant owner
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        unique case (state)
            IDLE: begin
                if (reqA && reqB)
                    state_nxt = last ? GNT_A : GNT_B;
                else if (reqA)
                    state_nxt = GNT_A;
                else if (reqB)
                    state_nxt = GNT_B;
            end
            GNT_A: begin
                if (!reqA)
                    state_nxt = reqB ? GNT_B : IDLE;
                else if (hold == HOLD_MAX && reqB)
                    state_nxt = GNT_B;
                else if (hold != HOLD_MAX)
                    hold_nxt = hold + 3'd1;
            end
            GNT_B: begin
                if (!reqB)
                    state_nxt = reqA ? GNT_A : IDLE;
                else if (hold == HOLD_MAX && reqA)
                    state_nxt = GNT_A;
                else if (hold != HOLD_MAX)
                    hold_nxt = hold + 3'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data stage: valid only while the owner is still requesting, data zeroed otherwise
    always_comb begin
        valid_nxt = ((state == GNT_A) && reqA) || ((state == GNT_B) && reqB);
        data_nxt  = '0;
        if (valid_nxt)
            data_nxt = (state == GNT_A) ? dataA : dataB;
    end

    // State, arbitration history, registered grant decodes and output data
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            hold      <= '0;
            gntA      <= 1'b0;
            gntB      <= 1'b0;
            sel       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            // Grant outputs are registered decodes of the next state so they
            // track the state register exactly, cycle for cycle.
            gntA  <= (state_nxt == GNT_A);
            gntB  <= (state_nxt == GNT_B);
            sel   <= (state_nxt == GNT_B);
            if (state_nxt != state && state_nxt != IDLE) begin
                hold <= 3'd1;
                last <= (state_nxt == GNT_B);
            end else begin
                hold <= hold_nxt;
            end
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench: directed vector table, MAX_HOLD=1 alternation sequence,
// and randomized traffic against a behavioural ownership model.
module tb_mux_share_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reqA = 1'b0;
    logic       reqB = 1'b0;
    logic [2:0] dataA = '0;
    logic [2:0] dataB = '0;

    logic       gA4, gB4, sel4, v4;
    logic [2:0] d4;
    logic       gA1, gB1, sel1, v1;
    logic [2:0] d1;

    int checks = 0;
    int failures = 0;

    mux_share_arbiter #(.MAX_HOLD(4)) u4 (
        .clk(clk), .reset(reset), .reqA(reqA), .reqB(reqB),
        .dataA(dataA), .dataB(dataB),
        .gntA(gA4), .gntB(gB4), .sel(sel4), .out_valid(v4), .out_data(d4)
    );

    mux_share_arbiter #(.MAX_HOLD(1)) u1 (
        .clk(clk), .reset(reset), .reqA(reqA), .reqB(reqB),
        .dataA(dataA), .dataB(dataB),
        .gntA(gA1), .gntB(gB1), .sel(sel1), .out_valid(v1), .out_data(d1)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns the channel, how long they have owned it
    // (unbounded count), and who was served last.
    typedef struct {
        int         owner;   // 0 none, 1 A, 2 B
        int         tenure;
        int         last;    // 1 A, 2 B
        bit         v;
        logic [2:0] d;
    } mdl_t;

    mdl_t m4, m1;

    function automatic mdl_t mreset();
        mdl_t s;
        s.owner = 0; s.tenure = 0; s.last = 2; s.v = 1'b0; s.d = 3'd0;
        return s;
    endfunction

    function automatic mdl_t mstep(mdl_t s, bit rst, bit ra, bit rb,
                                   logic [2:0] da, logic [2:0] db, int maxh);
        mdl_t n;
        bit   want [3];
        int   other;
        if (rst) return mreset();
        n = s;
        want[0] = 1'b0; want[1] = ra; want[2] = rb;
        n.v = (s.owner != 0) && want[s.owner];
        n.d = !n.v ? 3'd0 : (s.owner == 1 ? da : db);
        if (s.owner == 0) begin
            if (ra && rb) n.owner = 3 - s.last;
            else if (ra)  n.owner = 1;
            else if (rb)  n.owner = 2;
            if (n.owner != 0) begin n.tenure = 1; n.last = n.owner; end
        end else begin
            other = 3 - s.owner;
            if (!want[s.owner] || (want[other] && s.tenure >= maxh)) begin
                if (want[other]) begin
                    n.owner = other; n.tenure = 1; n.last = other;
                end else begin
                    n.owner = 0;
                end
            end else begin
                n.tenure = s.tenure + 1;
            end
        end
        return n;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cmp_model(string tag, mdl_t m, logic ga, logic gb,
                             logic s, logic v, logic [2:0] d);
        chk({tag, " gntA"}, int'(ga), int'(m.owner == 1));
        chk({tag, " gntB"}, int'(gb), int'(m.owner == 2));
        chk({tag, " sel"}, int'(s), int'(m.owner == 2));
        chk({tag, " out_valid"}, int'(v), int'(m.v));
        chk({tag, " out_data"}, int'(d), int'(m.d));
        chk({tag, " exclusive"}, int'(ga & gb), 0);
    endtask

    // Drive inputs, take one edge, advance models, compare both DUTs after the edge
    task automatic cycle(bit rst, bit ra, bit rb, logic [2:0] da, logic [2:0] db,
                         string tag);
        reset = rst; reqA = ra; reqB = rb; dataA = da; dataB = db;
        @(posedge clk);
        m4 = mstep(m4, rst, ra, rb, da, db, 4);
        m1 = mstep(m1, rst, ra, rb, da, db, 1);
        #1;
        cmp_model({tag, " m4"}, m4, gA4, gB4, sel4, v4, d4);
        cmp_model({tag, " m1"}, m1, gA1, gB1, sel1, v1, d1);
    endtask

    typedef struct {
        bit         rst, ra, rb;
        logic [2:0] da, db;
        bit         ega, egb, esel, ev;
        logic [2:0] ed;
    } vec_t;

    function automatic vec_t mk(bit rst, bit ra, bit rb, logic [2:0] da, logic [2:0] db,
                                bit ega, bit egb, bit ev, logic [2:0] ed);
        vec_t t;
        t.rst = rst; t.ra = ra; t.rb = rb; t.da = da; t.db = db;
        t.ega = ega; t.egb = egb; t.esel = egb; t.ev = ev; t.ed = ed;
        return t;
    endfunction

    vec_t tbl [26];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit prev_sel, prev_ga;
        // Expected outputs below are for the MAX_HOLD=4 instance.
        //           rst ra rb  da    db    gA gB  v  d
        tbl[0]  = mk(1, 1, 1, 3'd5, 3'd0, 0, 0, 0, 3'd0); // reset held
        tbl[1]  = mk(1, 1, 1, 3'd5, 3'd0, 0, 0, 0, 3'd0);
        tbl[2]  = mk(0, 1, 1, 3'd1, 3'd6, 1, 0, 0, 3'd0); // tie -> A first
        tbl[3]  = mk(0, 1, 1, 3'd1, 3'd6, 1, 0, 1, 3'd1);
        tbl[4]  = mk(0, 1, 1, 3'd1, 3'd6, 1, 0, 1, 3'd1);
        tbl[5]  = mk(0, 1, 1, 3'd1, 3'd6, 1, 0, 1, 3'd1);
        tbl[6]  = mk(0, 1, 1, 3'd1, 3'd6, 0, 1, 1, 3'd1); // switch, data lags sel
        tbl[7]  = mk(0, 1, 1, 3'd1, 3'd6, 0, 1, 1, 3'd6);
        tbl[8]  = mk(0, 1, 1, 3'd1, 3'd6, 0, 1, 1, 3'd6);
        tbl[9]  = mk(0, 1, 1, 3'd1, 3'd6, 0, 1, 1, 3'd6);
        tbl[10] = mk(0, 1, 1, 3'd1, 3'd6, 1, 0, 1, 3'd6); // back to A
        tbl[11] = mk(0, 1, 1, 3'd1, 3'd6, 1, 0, 1, 3'd1);
        tbl[12] = mk(0, 0, 1, 3'd1, 3'd6, 0, 1, 0, 3'd0); // early release, no gap
        tbl[13] = mk(0, 0, 1, 3'd1, 3'd6, 0, 1, 1, 3'd6);
        tbl[14] = mk(1, 1, 1, 3'd1, 3'd6, 0, 0, 0, 3'd0); // reset mid-transfer
        tbl[15] = mk(0, 1, 1, 3'd1, 3'd6, 1, 0, 0, 3'd0); // last=B so A first
        tbl[16] = mk(0, 0, 0, 3'd1, 3'd6, 0, 0, 0, 3'd0); // release to IDLE
        tbl[17] = mk(0, 1, 0, 3'd3, 3'd6, 1, 0, 0, 3'd0); // single requester
        tbl[18] = mk(0, 1, 0, 3'd3, 3'd6, 1, 0, 1, 3'd3);
        tbl[19] = mk(0, 1, 0, 3'd3, 3'd6, 1, 0, 1, 3'd3);
        tbl[20] = mk(0, 1, 0, 3'd3, 3'd6, 1, 0, 1, 3'd3);
        tbl[21] = mk(0, 1, 0, 3'd3, 3'd6, 1, 0, 1, 3'd3); // hold saturated
        tbl[22] = mk(0, 1, 0, 3'd3, 3'd6, 1, 0, 1, 3'd3);
        tbl[23] = mk(0, 1, 1, 3'd3, 3'd6, 0, 1, 1, 3'd3); // saturated -> immediate switch
        tbl[24] = mk(0, 0, 0, 3'd3, 3'd6, 0, 0, 0, 3'd0);
        tbl[25] = mk(0, 0, 0, 3'd3, 3'd6, 0, 0, 0, 3'd0);

        m4 = mreset();
        m1 = mreset();
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(tbl[i].rst, tbl[i].ra, tbl[i].rb, tbl[i].da, tbl[i].db, tag);
            chk({tag, " tbl gntA"}, int'(gA4), int'(tbl[i].ega));
            chk({tag, " tbl gntB"}, int'(gB4), int'(tbl[i].egb));
            chk({tag, " tbl sel"}, int'(sel4), int'(tbl[i].esel));
            chk({tag, " tbl out_valid"}, int'(v4), int'(tbl[i].ev));
            chk({tag, " tbl out_data"}, int'(d4), int'(tbl[i].ed));
        end

        // MAX_HOLD=1: continuous contention alternates every cycle
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, "mh1 reset");
        cycle(1'b0, 1'b1, 1'b1, 3'd2, 3'd5, "mh1 first");
        chk("mh1 first grant A", int'(gA1), 1);
        prev_sel = sel1;
        prev_ga  = gA1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 3'd2, 3'd5, $sformatf("mh1 alt%0d", i));
            chk($sformatf("mh1 sel toggle%0d", i), int'(sel1), int'(!prev_sel));
            chk($sformatf("mh1 gntA toggle%0d", i), int'(gA1), int'(!prev_ga));
            prev_sel = sel1;
            prev_ga  = gA1;
        end

        // Randomized traffic; requests are sticky-ish so tenures get exercised
        for (int i = 0; i < 400; i++) begin
            bit ra, rb, rst;
            rst = ($urandom_range(0, 99) < 3);
            ra  = ($urandom_range(0, 99) < 70) ? reqA : !reqA;
            rb  = ($urandom_range(0, 99) < 70) ? reqB : !reqB;
            cycle(rst, ra, rb, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
